puck_ctl: RTL and testbench
===========================

Name: puck_ctl

Overview:
- Frame-rate puck physics engine for the air-hockey field.
- Consumes the mallet centre from the mallet position controller and the vsync from the VGA timing generator.
- Produces the puck centre for a downstream circle draw stage, plus goal pulses and scores.
- Runs once per frame, during vertical sync; outputs are held stable for the whole active video period.

Parameters:
FIELD_W, 1024, field width in pixels (x range 0..FIELD_W-1)
FIELD_H, 768, field height in pixels (y range 0..FIELD_H-1)
PUCK_R, 16, puck radius
MALLET_R, 32, mallet radius
MAX_SPEED, 8, velocity magnitude limit per axis, pixels/frame
GOAL_Y_MIN, 284, goal mouth top (inclusive)
GOAL_Y_MAX, 484, goal mouth bottom (inclusive)
SERVE_FRAMES, 60, frames the puck is held at centre before play
FRICTION_FRAMES, 16, frames between velocity decay steps

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-low reset
vsync  input  1  vertical sync from VGA timing, active high
mallet_x  input  12  mallet centre x, unsigned
mallet_y  input  12  mallet centre y, unsigned
xpos  output  12  puck centre x
ypos  output  12  puck centre y
goal_l  output  1  one-clk pulse: puck entered the left goal (point to right player)
goal_r  output  1  one-clk pulse: puck entered the right goal (point to left player)
score_l  output  4  left player score
score_r  output  4  right player score

Behaviour:
- Reset (rst=0, async):
  - xpos=FIELD_W/2, ypos=FIELD_H/2.
  - vx=vy=0. Scores 0, goal pulses 0.
  - Mode SERVE; serve counter=SERVE_FRAMES; friction counter=0.
- Frame tick: rising edge of vsync, detected with a registered previous value. Tick is asserted one clk after the edge.
- Update FSM: IDLE -> HIT -> MOVE -> WALL -> COMMIT -> IDLE, one clk per state, so 4 clks after the tick.
  - Ticks arriving outside IDLE are ignored.
  - xpos/ypos change only in COMMIT.
- Mode SERVE:
  - Each tick decrements the serve counter. Puck stays at centre with v=0.
  - When the counter reaches 0, the mode becomes PLAY. The move step starts on the following tick.
- HIT (PLAY only):
  - dx=xpos-mallet_x, dy=ypos-mallet_y, signed 13 bit.
  - Hit if dx*dx+dy*dy <= (PUCK_R+MALLET_R)^2, evaluated at ≥26 bits, no overflow.
  - On hit: vx=sat(dx>>>2), vy=sat(dy>>>2), where sat clamps to ±MAX_SPEED.
  - If both results are 0, vx=+1.
- MOVE:
  - nx=xpos+vx, ny=ypos+vy, signed 13 bit.
  - Friction counter increments every PLAY tick. At FRICTION_FRAMES-1 it wraps to 0, and each nonzero velocity component moves 1 toward 0.
  - A hit and friction in the same frame: hit values are used, no decay applied.
- WALL:
  - ny-PUCK_R < 0 -> ny=PUCK_R, vy=-vy.
  - ny+PUCK_R > FIELD_H-1 -> ny=FIELD_H-1-PUCK_R, vy=-vy.
  - nx-PUCK_R < 0:
    - If GOAL_Y_MIN <= ny <= GOAL_Y_MAX: goal left.
    - Else nx=PUCK_R, vx=-vx.
  - Right side mirrors this: goal right, clamp nx=FIELD_W-1-PUCK_R.
  - The goal check uses ny after the top/bottom correction.
  - Corner case (both axes out of range): both reflections apply.
- COMMIT:
  - No goal: xpos/ypos <= nx/ny.
  - Goal:
    - Pulse goal_l or goal_r for exactly 1 clk.
    - Increment score_r (for goal_l) or score_l (for goal_r), saturating at 9.
    - Puck to centre, v=0, mode SERVE, serve counter=SERVE_FRAMES.
- Scores never clear except by reset.
- Reset asserted mid-update aborts immediately to reset values. No partial COMMIT occurs.

Test Plan:
- Reset release, 60 vsync pulses -> xpos=512, ypos=384 throughout; mode PLAY after the 60th tick; no goal pulse.
- PLAY, puck (512,384), mallet at (472,384): dx=40, 40²=1600 ≤ 48²=2304 -> vx=+8 (10 clamped), vy=0.
  - Next tick: xpos=520, then 528.
- Puck (20,100), vx=-8, vy=0 -> xpos=16, vx=+8. Next frame xpos=24; no goal (y outside mouth).
- Puck (20,384), vx=-8 -> goal_l high for exactly 1 clk; score_r=1; puck (512,384), v=0; 60-frame serve restarts.
- Ten right-goal events -> score_l stays at 9 after the ninth.
- Puck at (100,100) with vx=vy=+3, no hit, 16 ticks -> velocity becomes (2,2) at the 16th tick.
- Two vsync edges 2 clks apart -> second ignored, single update.
- rst pulsed low during the MOVE state -> outputs return to reset values asynchronously; no goal pulse.

Source files
------------

// File: rtl/puck_ctl_if.sv
// Signal bundle between the puck engine and the rest of the game.
// Inputs are vsync and the mallet centre; outputs are the puck centre, goal pulses and scores.
interface puck_ctl_if;
  logic        vsync;
  logic [11:0] mallet_x;
  logic [11:0] mallet_y;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        goal_l;
  logic        goal_r;
  logic [3:0]  score_l;
  logic [3:0]  score_r;

  modport master (output vsync, mallet_x, mallet_y,
                  input  xpos, ypos, goal_l, goal_r, score_l, score_r);
  modport slave  (input  vsync, mallet_x, mallet_y,
                  output xpos, ypos, goal_l, goal_r, score_l, score_r);
endinterface

// File: rtl/puck_ctl.sv
// Air-hockey puck physics: one update per vsync rising edge.
// The update sequence is HIT -> MOVE -> WALL -> COMMIT, and the outputs are held between updates.
module puck_ctl #(
  parameter int FIELD_W         = 1024,
  parameter int FIELD_H         = 768,
  parameter int PUCK_R          = 16,
  parameter int MALLET_R        = 32,
  parameter int MAX_SPEED       = 8,
  parameter int GOAL_Y_MIN      = 284,
  parameter int GOAL_Y_MAX      = 484,
  parameter int SERVE_FRAMES    = 60,
  parameter int FRICTION_FRAMES = 16
) (
  input  logic      clk,
  input  logic      rst,
  puck_ctl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_HIT, S_MOVE, S_WALL, S_COMMIT} state_t;
  typedef enum logic {M_SERVE, M_PLAY} mode_t;

  localparam logic [11:0]        L_CX        = 12'(FIELD_W / 2);
  localparam logic [11:0]        L_CY        = 12'(FIELD_H / 2);
  localparam logic signed [12:0] L_X_LO      = 13'(PUCK_R);
  localparam logic signed [12:0] L_X_HI      = 13'(FIELD_W - 1 - PUCK_R);
  localparam logic signed [12:0] L_Y_LO      = 13'(PUCK_R);
  localparam logic signed [12:0] L_Y_HI      = 13'(FIELD_H - 1 - PUCK_R);
  localparam logic signed [12:0] L_MOUTH_LO  = 13'(GOAL_Y_MIN);
  localparam logic signed [12:0] L_MOUTH_HI  = 13'(GOAL_Y_MAX);
  localparam logic signed [25:0] L_HIT_R2    = 26'((PUCK_R + MALLET_R) * (PUCK_R + MALLET_R));
  localparam logic signed [4:0]  L_VMAX      = 5'(MAX_SPEED);
  localparam logic [7:0]         L_SERVE     = 8'(SERVE_FRAMES);
  localparam logic [7:0]         L_FRIC_LAST = 8'(FRICTION_FRAMES - 1);
  localparam logic [3:0]         L_SCORE_MAX = 4'd9;

  function automatic logic signed [4:0] sat_v(input logic signed [12:0] d);
    logic signed [12:0] q;
    q = d >>> 2;
    if (q > 13'(L_VMAX))  return L_VMAX;
    if (q < -13'(L_VMAX)) return -L_VMAX;
    return 5'(q);
  endfunction

  function automatic logic signed [4:0] decay_v(input logic signed [4:0] v);
    if (v > 5'sd0) return v - 5'sd1;
    if (v < 5'sd0) return v + 5'sd1;
    return v;
  endfunction

  state_t             r_state, w_state_next;
  mode_t              r_mode;
  logic               r_vsync_prev;
  logic [7:0]         r_serve_cnt, r_fric_cnt;
  logic signed [4:0]  r_vx, r_vy;
  logic signed [12:0] r_nx, r_ny;
  logic               r_hit, r_goal_l_pend, r_goal_r_pend;
  logic [11:0]        r_xpos, r_ypos;
  logic [3:0]         r_score_l, r_score_r;
  logic               r_goal_l, r_goal_r;

  logic               w_tick;
  logic signed [12:0] w_dx, w_dy;
  logic signed [25:0] w_dist2;
  logic               w_hit;
  logic signed [4:0]  w_hit_vx, w_hit_vy;
  logic signed [12:0] w_nx, w_ny;
  logic signed [4:0]  w_vx, w_vy;
  logic               w_in_mouth, w_goal_l, w_goal_r;

  assign w_tick  = bus.vsync & ~r_vsync_prev;
  assign w_dx    = $signed({1'b0, r_xpos}) - $signed({1'b0, bus.mallet_x});
  assign w_dy    = $signed({1'b0, r_ypos}) - $signed({1'b0, bus.mallet_y});
  assign w_dist2 = 26'(w_dx) * 26'(w_dx) + 26'(w_dy) * 26'(w_dy);
  assign w_hit   = (w_dist2 <= L_HIT_R2);

  // A dead-centre hit still has to push the puck somewhere.
  always_comb begin
    w_hit_vx = sat_v(w_dx);
    w_hit_vy = sat_v(w_dy);
    if (w_hit_vx == 5'sd0 && w_hit_vy == 5'sd0) w_hit_vx = 5'sd1;
  end

  // Top/bottom first, so the goal-mouth test sees the corrected y.
  always_comb begin
    w_nx       = r_nx;
    w_ny       = r_ny;
    w_vx       = r_vx;
    w_vy       = r_vy;
    w_in_mouth = 1'b0;
    w_goal_l   = 1'b0;
    w_goal_r   = 1'b0;
    if (r_ny < L_Y_LO) begin
      w_ny = L_Y_LO;
      w_vy = -r_vy;
    end else if (r_ny > L_Y_HI) begin
      w_ny = L_Y_HI;
      w_vy = -r_vy;
    end
    w_in_mouth = (w_ny >= L_MOUTH_LO) && (w_ny <= L_MOUTH_HI);
    if (r_nx < L_X_LO) begin
      if (w_in_mouth) w_goal_l = 1'b1;
      else begin
        w_nx = L_X_LO;
        w_vx = -r_vx;
      end
    end else if (r_nx > L_X_HI) begin
      if (w_in_mouth) w_goal_r = 1'b1;
      else begin
        w_nx = L_X_HI;
        w_vx = -r_vx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick && r_mode == M_PLAY) w_state_next = S_HIT;
      S_HIT:    w_state_next = S_MOVE;
      S_MOVE:   w_state_next = S_WALL;
      S_WALL:   w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsync_prev  <= 1'b0;
      r_mode        <= M_SERVE;
      r_serve_cnt   <= L_SERVE;
      r_fric_cnt    <= 8'd0;
      r_vx          <= 5'sd0;
      r_vy          <= 5'sd0;
      r_nx          <= 13'sd0;
      r_ny          <= 13'sd0;
      r_hit         <= 1'b0;
      r_goal_l_pend <= 1'b0;
      r_goal_r_pend <= 1'b0;
      r_xpos        <= L_CX;
      r_ypos        <= L_CY;
      r_score_l     <= 4'd0;
      r_score_r     <= 4'd0;
      r_goal_l      <= 1'b0;
      r_goal_r      <= 1'b0;
    end else begin
      r_vsync_prev <= bus.vsync;
      r_goal_l     <= 1'b0;
      r_goal_r     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick && r_mode == M_SERVE) begin
            if (r_serve_cnt <= 8'd1) begin
              r_serve_cnt <= 8'd0;
              r_mode      <= M_PLAY;
            end else begin
              r_serve_cnt <= r_serve_cnt - 8'd1;
            end
          end
        end
        S_HIT: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_vx <= w_hit_vx;
            r_vy <= w_hit_vy;
          end
        end
        S_MOVE: begin
          r_nx <= $signed({1'b0, r_xpos}) + 13'(r_vx);
          r_ny <= $signed({1'b0, r_ypos}) + 13'(r_vy);
          // Decay affects the next frame; a fresh hit overrides it.
          if (r_fric_cnt == L_FRIC_LAST) begin
            r_fric_cnt <= 8'd0;
            if (!r_hit) begin
              r_vx <= decay_v(r_vx);
              r_vy <= decay_v(r_vy);
            end
          end else begin
            r_fric_cnt <= r_fric_cnt + 8'd1;
          end
        end
        S_WALL: begin
          r_nx          <= w_nx;
          r_ny          <= w_ny;
          r_vx          <= w_vx;
          r_vy          <= w_vy;
          r_goal_l_pend <= w_goal_l;
          r_goal_r_pend <= w_goal_r;
        end
        S_COMMIT: begin
          if (r_goal_l_pend || r_goal_r_pend) begin
            r_goal_l <= r_goal_l_pend;
            r_goal_r <= r_goal_r_pend;
            if (r_goal_l_pend && r_score_r < L_SCORE_MAX) r_score_r <= r_score_r + 4'd1;
            if (r_goal_r_pend && r_score_l < L_SCORE_MAX) r_score_l <= r_score_l + 4'd1;
            r_xpos      <= L_CX;
            r_ypos      <= L_CY;
            r_vx        <= 5'sd0;
            r_vy        <= 5'sd0;
            r_mode      <= M_SERVE;
            r_serve_cnt <= L_SERVE;
          end else begin
            r_xpos <= r_nx[11:0];
            r_ypos <= r_ny[11:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.xpos    = r_xpos;
  assign bus.ypos    = r_ypos;
  assign bus.goal_l  = r_goal_l;
  assign bus.goal_r  = r_goal_r;
  assign bus.score_l = r_score_l;
  assign bus.score_r = r_score_r;
endmodule

// File: tb/tb_puck_ctl.sv
// Scoreboard bench for puck_ctl: a frame-level integer model queues expected outputs,
// and a monitor compares them once each frame's update has settled.
module tb_puck_ctl;
  localparam int FW = 1024, FH = 768, PR = 16, MR = 32, VMAX = 8;
  localparam int GMIN = 284, GMAX = 484, SERVE = 60, FRIC = 16;

  typedef struct {
    int x; int y; int sl; int sr; int gl; int gr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  puck_ctl_if bus();

  puck_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  int n_issued = 0, n_checked = 0;
  int last_goal;

  // Reference model state, in plain integers.
  int m_x, m_y, m_vx, m_vy, m_serve_cnt, m_fric, m_sl, m_sr;
  bit m_serve;

  function automatic int clampv(input int v);
    if (v > VMAX) return VMAX;
    if (v < -VMAX) return -VMAX;
    return v;
  endfunction

  function automatic int floor4(input int v);
    if (v >= 0) return v / 4;
    return -((-v + 3) / 4);
  endfunction

  function automatic int toward0(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  function automatic int mclamp(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  function automatic void push_exp(input int gl, input int gr);
    exp_t e;
    e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.gl = gl; e.gr = gr;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_x = FW / 2; m_y = FH / 2; m_vx = 0; m_vy = 0;
    m_serve = 1'b1; m_serve_cnt = SERVE; m_fric = 0; m_sl = 0; m_sr = 0;
  endfunction

  function automatic void model_frame(input int mx, input int my);
    int dx, dy, nx, ny;
    bit hit;
    int gl = 0, gr = 0;
    if (m_serve) begin
      m_serve_cnt = m_serve_cnt - 1;
      if (m_serve_cnt <= 0) begin
        m_serve = 1'b0;
        m_serve_cnt = 0;
      end
    end else begin
      dx = m_x - mx;
      dy = m_y - my;
      hit = (dx * dx + dy * dy) <= (PR + MR) * (PR + MR);
      if (hit) begin
        m_vx = clampv(floor4(dx));
        m_vy = clampv(floor4(dy));
        if (m_vx == 0 && m_vy == 0) m_vx = 1;
      end
      nx = m_x + m_vx;
      ny = m_y + m_vy;
      if (m_fric == FRIC - 1) begin
        m_fric = 0;
        if (!hit) begin
          m_vx = toward0(m_vx);
          m_vy = toward0(m_vy);
        end
      end else begin
        m_fric = m_fric + 1;
      end
      if (ny < PR) begin ny = PR; m_vy = -m_vy; end
      else if (ny > FH - 1 - PR) begin ny = FH - 1 - PR; m_vy = -m_vy; end
      if (nx < PR) begin
        if (ny >= GMIN && ny <= GMAX) gl = 1;
        else begin nx = PR; m_vx = -m_vx; end
      end else if (nx > FW - 1 - PR) begin
        if (ny >= GMIN && ny <= GMAX) gr = 1;
        else begin nx = FW - 1 - PR; m_vx = -m_vx; end
      end
      if (gl != 0 || gr != 0) begin
        if (gl != 0 && m_sr < 9) m_sr = m_sr + 1;
        if (gr != 0 && m_sl < 9) m_sl = m_sl + 1;
        m_x = FW / 2; m_y = FH / 2; m_vx = 0; m_vy = 0;
        m_serve = 1'b1; m_serve_cnt = SERVE;
      end else begin
        m_x = nx;
        m_y = ny;
      end
    end
    last_goal = (gl != 0) ? 1 : ((gr != 0) ? 2 : 0);
    push_exp(gl, gr);
  endfunction

  function automatic void check(input string name, input int act, input int exp_v);
    n_assert++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (txn %0d)", name, act, exp_v, n_checked);
    end
  endfunction

  task automatic frame(input int mx, input int my);
    bus.mallet_x = 12'(mclamp(mx));
    bus.mallet_y = 12'(mclamp(my));
    model_frame(mclamp(mx), mclamp(my));
    @(posedge clk); #1 bus.vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.vsync = 1'b0;
    repeat (8) @(posedge clk);
    #1 n_issued++;
  endtask

  // Two rising edges two clocks apart: the second lands mid-update and must be dropped.
  task automatic frame_double(input int mx, input int my);
    bus.mallet_x = 12'(mx);
    bus.mallet_y = 12'(my);
    model_frame(mx, my);
    @(posedge clk); #1 bus.vsync = 1'b1;
    @(posedge clk); #1 bus.vsync = 1'b0;
    @(posedge clk); #1 bus.vsync = 1'b1;
    @(posedge clk); #1 bus.vsync = 1'b0;
    repeat (8) @(posedge clk);
    #1 n_issued++;
  endtask

  task automatic reset_mid_move(input int mx, input int my);
    bus.mallet_x = 12'(mx);
    bus.mallet_y = 12'(my);
    @(posedge clk); #1 bus.vsync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    bus.vsync = 1'b0;
    model_reset();
    push_exp(0, 0);
    #1 n_issued++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic goal_run(input int dir);
    int k;
    k = 0;
    last_goal = 0;
    while (last_goal == 0 && k < 200) begin
      frame(m_x - dir * 40, m_y);
      k++;
    end
    repeat (SERVE) frame(4000, 4000);
  endtask

  // Monitor: counts goal-pulse clocks and checks each settled frame against the scoreboard.
  initial begin
    int gl_cyc, gr_cyc;
    exp_t e;
    gl_cyc = 0;
    gr_cyc = 0;
    forever begin
      @(negedge clk);
      gl_cyc += int'(bus.goal_l);
      gr_cyc += int'(bus.goal_r);
      if (n_issued > n_checked) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("xpos", int'(bus.xpos), e.x);
          check("ypos", int'(bus.ypos), e.y);
          check("score_l", int'(bus.score_l), e.sl);
          check("score_r", int'(bus.score_r), e.sr);
          check("goal_l_clks", gl_cyc, e.gl);
          check("goal_r_clks", gr_cyc, e.gr);
          $display("txn %0d pos=(%0d,%0d) score=%0d:%0d goal_l=%0d goal_r=%0d",
                   n_checked, bus.xpos, bus.ypos, bus.score_l, bus.score_r, gl_cyc, gr_cyc);
        end
        n_checked++;
        gl_cyc = 0;
        gr_cyc = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checked, expected %0d", n_checked, n_issued);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.vsync = 1'b0;
    bus.mallet_x = '0;
    bus.mallet_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 push_exp(0, 0);
    n_issued++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    repeat (SERVE) frame(int'($urandom_range(4095)), int'($urandom_range(4095)));
    frame(472, 384);
    frame(472, 384);
    frame_double(4000, 4000);
    goal_run(-1);
    repeat (10) goal_run(1);
    repeat (100) frame(m_x + 40, m_y + 40);
    repeat (100) frame(4000, 4000);
    repeat (200) frame(m_x + int'($urandom_range(100)) - 50, m_y + int'($urandom_range(100)) - 50);
    while (m_serve) frame(4000, 4000);
    frame(m_x + 40, m_y + 20);
    reset_mid_move(4000, 4000);
    repeat (5) frame(4000, 4000);

    repeat (3) @(posedge clk);
    #1 check("all_checked", n_checked, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
